// File: rtl/ex_mem_skid_reg.sv
// Execute->memory pipeline register with a 2-entry skid buffer.
// Define EXMEM_PERF_CNT_EN to add the stall_cnt output.
module ex_mem_skid_reg #(
  parameter int XLEN = 64,
  parameter int OPW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_wen,
  input  logic [OPW-1:0]  in_opcode_info,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_wen,
  output logic [OPW-1:0]  out_opcode_info
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
    logic            wen;
    logic [OPW-1:0]  op;
  } op_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BUSY,
    S_FULL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  op_t    r_main;
  op_t    r_skid;
  op_t    w_main_nxt;
  op_t    w_skid_nxt;
  op_t    w_in;
  logic   w_in_fire;
  logic   w_out_fire;

  assign w_in.pc  = in_pc;
  assign w_in.alu = in_alu_result;
  assign w_in.sd  = in_store_data;
  assign w_in.rd  = in_rd;
  assign w_in.wen = in_reg_wen;
  assign w_in.op  = in_opcode_info;

  // in_ready comes from registered state only, never from out_ready
  assign in_ready   = (r_state != S_FULL) & ~rst;
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_main_nxt  = w_in;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = w_in;
        end else if (w_in_fire) begin
          w_skid_nxt  = w_in;
          w_state_nxt = S_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_main_nxt  = r_skid;
          w_state_nxt = S_BUSY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Redirect kills both slots; the data is left stale but invisible
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
    end
  end

  assign out_pc          = r_main.pc;
  assign out_alu_result  = r_main.alu;
  assign out_store_data  = r_main.sd;
  assign out_rd          = r_main.rd;
  assign out_opcode_info = r_main.op;
  assign out_reg_wen     = r_main.wen & out_valid
                         & (r_main.rd != 5'd0);

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready
                 && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Randomized and directed bench for ex_mem_skid_reg.
// Reference model is a 2-deep ordered queue of accepted ops.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_wen;
  logic [1:0]  in_opcode_info;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_alu_result;
  logic [63:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_wen;
  logic [1:0]  out_opcode_info;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  op;
  } op_t;

  ex_mem_skid_reg #(.XLEN(64), .OPW(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_alu_result   (in_alu_result),
    .in_store_data   (in_store_data),
    .in_rd           (in_rd),
    .in_reg_wen      (in_reg_wen),
    .in_opcode_info  (in_opcode_info),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_alu_result  (out_alu_result),
    .out_store_data  (out_store_data),
    .out_rd          (out_rd),
    .out_reg_wen     (out_reg_wen),
    .out_opcode_info (out_opcode_info)
`ifdef EXMEM_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic op_t act();
    op_t a;
    a.pc  = out_pc;
    a.alu = out_alu_result;
    a.sd  = out_store_data;
    a.rd  = out_rd;
    a.wen = dut.r_main.wen;
    a.op  = out_opcode_info;
    return a;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.pc  = {$urandom, $urandom};
    o.alu = {$urandom, $urandom};
    o.sd  = {$urandom, $urandom};
    o.rd  = 5'($urandom_range(0, 31));
    o.wen = 1'($urandom_range(0, 1));
    o.op  = 2'($urandom_range(0, 3));
    return o;
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc,
                       input logic [4:0] rd, input logic wen);
    in_valid       = v;
    in_pc          = pc;
    in_alu_result  = pc + 64'h1000;
    in_store_data  = ~pc;
    in_rd          = rd;
    in_reg_wen     = wen;
    in_opcode_info = pc[3:2];
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 64'hDEAD, 5'd3, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    n_cmp++;
    if (out_pc !== 64'h0) begin
      n_err++; $display("FAIL rst_out_pc got %h want 0", out_pc);
    end
    n_cmp++;
    if (out_alu_result !== 64'h0) begin
      n_err++; $display("FAIL rst_out_alu got %h want 0", out_alu_result);
    end
    n_cmp++;
    if (out_store_data !== 64'h0) begin
      n_err++; $display("FAIL rst_out_sd got %h want 0", out_store_data);
    end
    n_cmp++;
    if ({out_rd, out_opcode_info, out_reg_wen} !== 8'h0) begin
      n_err++;
      $display("FAIL rst_out_misc got %h want 0",
               {out_rd, out_opcode_info, out_reg_wen});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL post_rst_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_rst_out_valid got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 64'h100 + 64'(4 * i), 5'd1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready);
      end
      n_cmp++;
      if (out_valid !== (i >= 1 && i <= 3)) begin
        n_err++; $display("FAIL stream_out_valid[%0d] got %b", i, out_valid);
      end
      if (i >= 1 && i <= 3) begin
        exp_pc = 64'h100 + 64'(4 * (i - 1));
        n_cmp++;
        if (out_pc !== exp_pc) begin
          n_err++;
          $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, exp_pc);
        end
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc [7];
    logic        exp_rdy [7];
    logic        exp_vld [7];
    exp_pc  = '{64'h0, 64'h200, 64'h200, 64'h200, 64'h200, 64'h204, 64'h0};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(i < 2, 64'h200 + 64'(4 * i), 5'd2, 1'b1);
      out_ready = (i >= 4);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== exp_rdy[i]) begin
        n_err++;
        $display("FAIL bp_in_ready[%0d] got %b want %b", i, in_ready, exp_rdy[i]);
      end
      n_cmp++;
      if (out_valid !== exp_vld[i]) begin
        n_err++;
        $display("FAIL bp_out_valid[%0d] got %b want %b", i, out_valid, exp_vld[i]);
      end
      if (exp_vld[i]) begin
        n_cmp++;
        if (out_pc !== exp_pc[i]) begin
          n_err++;
          $display("FAIL bp_pc[%0d] got %h want %h", i, out_pc, exp_pc[i]);
        end
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 64'h300, 5'd4, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 64'h304, 5'd4, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 64'h308, 5'd4, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_full_in_ready got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_full_out_valid[%0d] got %b pc %h want 0",
                 i, out_valid, out_pc);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    drive(1'b1, 64'h310, 5'd4, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 64'h30C, 5'd4, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_busy_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_busy_out_valid[%0d] got %b pc %h want 0",
                 i, out_valid, out_pc);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_x0();
    out_ready = 1'b1;
    drive(1'b1, 64'h400, 5'd0, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 64'h404, 5'd5, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_reg_wen} !== 2'b10) begin
      n_err++;
      $display("FAIL x0_wen got valid %b wen %b want 1 0", out_valid, out_reg_wen);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_reg_wen, out_rd} !== {2'b11, 5'd5}) begin
      n_err++;
      $display("FAIL rd5_wen got valid %b wen %b rd %0d want 1 1 5",
               out_valid, out_reg_wen, out_rd);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_random();
    op_t q[$];
    op_t o;
    op_t e;
    logic f_in;
    logic f_out;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] exp_cnt;
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef EXMEM_PERF_CNT_EN
    exp_cnt = 32'd0;
`endif
    for (int c = 0; c < 600; c++) begin
      o = rand_op();
      in_pc          = o.pc;
      in_alu_result  = o.alu;
      in_store_data  = o.sd;
      in_rd          = o.rd;
      in_reg_wen     = o.wen;
      in_opcode_info = o.op;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== (q.size() < 2 && !rst)) begin
        n_err++;
        $display("FAIL rnd_in_ready[%0d] got %b depth %0d", c, in_ready, q.size());
      end
      n_cmp++;
      if (out_valid !== (q.size() > 0)) begin
        n_err++;
        $display("FAIL rnd_out_valid[%0d] got %b depth %0d", c, out_valid, q.size());
      end
      if (q.size() > 0) begin
        e = q[0];
        n_cmp++;
        if (act() !== e) begin
          n_err++;
          $display("FAIL rnd_data[%0d] got %h want %h", c, act(), e);
        end
        n_cmp++;
        if (out_reg_wen !== (e.wen && e.rd != 5'd0)) begin
          n_err++;
          $display("FAIL rnd_reg_wen[%0d] got %b rd %0d wen %b",
                   c, out_reg_wen, e.rd, e.wen);
        end
      end
`ifdef EXMEM_PERF_CNT_EN
      n_cmp++;
      if (stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL rnd_stall_cnt[%0d] got %0d want %0d", c, stall_cnt, exp_cnt);
      end
`endif
      f_in  = in_valid && q.size() < 2 && !rst;
      f_out = q.size() > 0 && out_ready;
      if (rst) begin
        q.delete();
`ifdef EXMEM_PERF_CNT_EN
        exp_cnt = 32'd0;
`endif
      end else begin
`ifdef EXMEM_PERF_CNT_EN
        if (q.size() > 0 && !out_ready && exp_cnt != 32'hFFFF_FFFF)
          exp_cnt = exp_cnt + 32'd1;
`endif
        if (f_out) void'(q.pop_front());
        if (flush) q.delete();
        else if (f_in) q.push_back(o);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drain();
  endtask

`ifdef EXMEM_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 64'h500, 5'd6, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 32'd7) begin
      n_err++; $display("FAIL perf_stall7 got %0d want 7", stall_cnt);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 32'd7) begin
      n_err++; $display("FAIL perf_flush got %0d want 7", stall_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_err++; $display("FAIL perf_rst got %0d want 0", stall_cnt);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_x0();
    test_random();
`ifdef EXMEM_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
